// File: rtl/noc_port_mux2.sv
// Two-input flit mux for the router output port: one-hot select on sel[1:0],
// one registered stage, data forced to zero whenever the output flit is not valid.
module noc_port_mux2 #(
  parameter int DATA_W = 66,
  parameter int VCH_W  = 2,
  parameter int SEL_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] idata_0,
  input  logic              ivalid_0,
  input  logic [VCH_W-1:0]  ivch_0,
  input  logic [DATA_W-1:0] idata_1,
  input  logic              ivalid_1,
  input  logic [VCH_W-1:0]  ivch_1,
  input  logic [SEL_W-1:0]  sel,
  output logic [DATA_W-1:0] odata,
  output logic              ovalid,
  output logic [VCH_W-1:0]  ovch
);

  // Channel semantics: a flit transfers on every cycle its valid is high;
  // there is no ready, so downstream must accept one flit per cycle.
  logic              pick_0;
  logic              pick_1;
  logic [DATA_W-1:0] data_next;
  logic              valid_next;
  logic [VCH_W-1:0]  vch_next;
  logic              unused_sel;

  // Only the two low select bits route this mux; the rest belong to other ports.
  assign unused_sel = ^sel;

  always_comb begin
    pick_0     = (sel[1:0] == 2'b01);
    pick_1     = (sel[1:0] == 2'b10);
    data_next  = '0;
    valid_next = 1'b0;
    vch_next   = '0;
    if (pick_0) begin
      valid_next = ivalid_0;
      vch_next   = ivch_0;
      // Gate payload on invalid cycles to keep the output bus quiet.
      if (ivalid_0) data_next = idata_0;
    end else if (pick_1) begin
      valid_next = ivalid_1;
      vch_next   = ivch_1;
      if (ivalid_1) data_next = idata_1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      odata  <= '0;
      ovalid <= 1'b0;
      ovch   <= '0;
    end else begin
      odata  <= data_next;
      ovalid <= valid_next;
      ovch   <= vch_next;
    end
  end

endmodule

// File: tb/tb_noc_port_mux2.sv
// Randomized and directed bench for noc_port_mux2, scored against a
// per-cycle reference model of the select/gating rules.
module tb_noc_port_mux2;

  localparam int DW = 66;
  localparam int VW = 2;
  localparam int SW = 5;
  localparam int OW = DW + 1 + VW;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] idata_0, idata_1;
  logic          ivalid_0, ivalid_1;
  logic [VW-1:0] ivch_0, ivch_1;
  logic [SW-1:0] sel;
  logic [DW-1:0] odata;
  logic          ovalid;
  logic [VW-1:0] ovch;

  logic [OW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int vrun   = 0;

  always #5 clk = ~clk;

  noc_port_mux2 #(.DATA_W(DW), .VCH_W(VW), .SEL_W(SW)) dut (
    .clk(clk), .rst(rst),
    .idata_0(idata_0), .ivalid_0(ivalid_0), .ivch_0(ivch_0),
    .idata_1(idata_1), .ivalid_1(ivalid_1), .ivch_1(ivch_1),
    .sel(sel), .odata(odata), .ovalid(ovalid), .ovch(ovch)
  );

  task automatic check(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] want);
    checks++;
    if (obs !== want) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", tag, obs, want, $time);
    end
  endtask

  // Reference: pick a port index from the select code, then apply the rules.
  function automatic logic [OW-1:0] model();
    logic [DW-1:0] d[2];
    logic          v[2];
    logic [VW-1:0] c[2];
    int            p;
    d[0] = idata_0; v[0] = ivalid_0; c[0] = ivch_0;
    d[1] = idata_1; v[1] = ivalid_1; c[1] = ivch_1;
    if (rst) return '0;
    p = -1;
    if (sel[1:0] == 2'b01) p = 0;
    if (sel[1:0] == 2'b10) p = 1;
    if (p < 0) return '0;
    return {(v[p] ? d[p] : {DW{1'b0}}), v[p], c[p]};
  endfunction

  function automatic logic [DW-1:0] rand_flit();
    return DW'({$urandom(), $urandom(), $urandom()});
  endfunction

  task automatic cyc();
    logic [OW-1:0] e;
    exp_q.push_back(model());
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("odata",  OW'(odata),  OW'(e[OW-1:VW+1]));
    check("ovalid", OW'(ovalid), OW'(e[VW]));
    check("ovch",   OW'(ovch),   OW'(e[VW-1:0]));
    if (ovalid) vrun++;
    else vrun = 0;
  endtask

  logic [16:0] pat[4];
  int r;

  initial begin
    pat[0] = 17'h0; pat[1] = 17'h1FFC0; pat[2] = 17'h00FFF; pat[3] = 17'h00001;
    rst = 1'b1;
    idata_0 = rand_flit(); ivalid_0 = 1'b1; ivch_0 = 2'd3;
    idata_1 = rand_flit(); ivalid_1 = 1'b1; ivch_1 = 2'd1;
    sel = 5'b00001;

    // Reset held two cycles, then first released edge loads port 0.
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
    check("load_port0", OW'(odata), OW'(idata_0));

    // Idle cycle so the valid-run counter starts from zero.
    sel = 5'b00000;
    cyc();

    // Port 1 stream: head, 20 data flits, tail; port 0 noise.
    sel = 5'b00010;
    ivch_1 = 2'd1;
    for (int i = 0; i < 22; i++) begin
      if (i == 0) idata_1 = {2'b01, 32'h0, 32'h4};
      else if (i == 21) idata_1 = {2'b10, 32'hdead_beef, 32'h0000_0021};
      else idata_1 = DW'(pat[(i - 1) % 4]);
      ivalid_1 = 1'b1;
      idata_0  = rand_flit();
      ivalid_0 = 1'($urandom_range(0, 1));
      ivch_0   = VW'($urandom_range(0, 3));
      cyc();
    end
    check("stream_run", OW'(vrun), OW'(22));

    // Port 0 select.
    sel = 5'b00001; idata_0 = 66'h0_0000_0000_0000_0009; ivch_0 = 2'd2; ivalid_0 = 1'b1;
    cyc();
    check("port0_value", OW'({odata, ovalid, ovch}), {66'h9, 1'b1, 2'd2});

    // Invalid data gating on port 1.
    sel = 5'b00010; ivalid_1 = 1'b0; idata_1 = '1;
    cyc();

    // No select, illegal select, upper bits only.
    ivalid_0 = 1'b1; ivalid_1 = 1'b1; idata_1 = rand_flit();
    sel = 5'b00000; cyc();
    sel = 5'b00011; cyc();
    sel = 5'b11100; cyc();

    // Switch between consecutive flits.
    sel = 5'b00001; idata_0 = rand_flit(); cyc();
    sel = 5'b00010; idata_1 = rand_flit(); cyc();

    // Reset mid-stream drops the flit, then output resumes.
    rst = 1'b1; idata_1 = rand_flit(); cyc();
    rst = 1'b0; idata_1 = rand_flit(); cyc();

    // Random traffic with occasional resets and stray select codes.
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 7);
      if (r < 3) sel = SW'($urandom_range(0, 7) << 2) | 5'b00001;
      else if (r < 6) sel = SW'($urandom_range(0, 7) << 2) | 5'b00010;
      else sel = SW'($urandom_range(0, 31));
      idata_0  = rand_flit();
      idata_1  = rand_flit();
      ivalid_0 = 1'($urandom_range(0, 1));
      ivalid_1 = 1'($urandom_range(0, 1));
      ivch_0   = VW'($urandom_range(0, 3));
      ivch_1   = VW'($urandom_range(0, 3));
      rst      = ($urandom_range(0, 49) == 0);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
